// File: rtl/insn_fetch_queue_pkg.sv
// Shared instruction-format definitions for the fetch queue and the decoder.
// Opcode field position, opcode codes, address width and the fetch FSM states.
package insn_fetch_queue_pkg;

  localparam int IMEM_AW = 13;
  localparam int INSN_DW = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_LOAD  = 5'h01;
  localparam logic [4:0] OP_STORE = 5'h02;
  localparam logic [4:0] OP_MAC   = 5'h03;
  localparam logic [4:0] OP_ACT   = 5'h04;
  localparam logic [4:0] OP_SYNC  = 5'h05;
  localparam logic [4:0] OP_EOC   = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [4:0] insn_opcode(input logic [INSN_DW-1:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/insn_fetch_queue_sync_fifo.sv
// Registered (non fall-through) FIFO with occupancy count and synchronous clear.
// Clear wipes storage too, so the head reads as zero after reset or flush.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 45
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;

  // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/insn_fetch_queue.sv
// Instruction prefetch queue: sequential reads from a 1-cycle SRAM into a small
// FIFO, handed to the decoder over valid/ready, stopping after the EOC word.
module insn_fetch_queue
  import insn_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = IMEM_AW,
  parameter int DW    = INSN_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          flush,
  output logic          imem_ren,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic          insn_valid,
  output logic [DW-1:0] insn_data,
  output logic [AW-1:0] insn_addr,
  input  logic          insn_ready,
  output logic          busy,
  output logic          halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DW + AW;

  fetch_state_t  state_r, state_nxt_s;
  logic [AW-1:0] fptr_r, fptr_base_s, raddr_r, ret_addr_r;
  logic          ren_r, inflight_r, busy_r, halted_r;
  logic          start_go_s, push_s, pop_s, clr_s, eoc_ret_s, head_eoc_s, ren_nxt_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   occ_nxt_s;
  logic [EW-1:0] head_s;

  // A return is only accepted while fetching; this drops the one read issued
  // alongside the EOC return, and inflight_r cleared by flush kills the other.
  assign clr_s      = rst | flush;
  assign push_s     = inflight_r & (state_r == ST_FETCH);
  assign eoc_ret_s  = push_s & (insn_opcode(imem_rdata) == OP_EOC);
  assign insn_valid = (count_s != {CW{1'b0}});
  assign pop_s      = insn_valid & insn_ready;
  assign head_eoc_s = (insn_opcode(head_s[EW-1:AW]) == OP_EOC);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push_s),
    .push_data ({imem_rdata, ret_addr_r}),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Next state, and whether a read is issued next cycle (occupancy counts the in-flight read)
  always_comb begin
    state_nxt_s = state_r;
    start_go_s  = 1'b0;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_nxt_s = ST_FETCH;
            start_go_s  = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_FETCH: begin
          if (eoc_ret_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (pop_s && head_eoc_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
    fptr_base_s = start_go_s ? start_addr : fptr_r;
    occ_nxt_s   = {1'b0, count_s} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s}
                + {{CW{1'b0}}, ren_r};
    ren_nxt_s   = (state_nxt_s == ST_FETCH) && (occ_nxt_s < (CW+1)'(DEPTH));
  end

  // FSM state, fetch pointer, read pipeline and registered status outputs
  always_ff @(posedge clk) begin
    if (clr_s) begin
      state_r    <= ST_IDLE;
      fptr_r     <= {AW{1'b0}};
      raddr_r    <= {AW{1'b0}};
      ret_addr_r <= {AW{1'b0}};
      ren_r      <= 1'b0;
      inflight_r <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ren_r      <= ren_nxt_s;
      inflight_r <= ren_r;
      ret_addr_r <= raddr_r;
      busy_r     <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DRAIN);
      halted_r   <= (state_nxt_s == ST_HALT);
      if (ren_nxt_s) begin
        raddr_r <= fptr_base_s;
        fptr_r  <= fptr_base_s + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        raddr_r <= raddr_r;
        fptr_r  <= fptr_base_s;
      end
    end
  end

  assign imem_ren  = ren_r;
  assign imem_addr = raddr_r;
  assign insn_data = head_s[EW-1:AW];
  assign insn_addr = head_s[AW-1:0];
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for insn_fetch_queue: behavioural 1-cycle SRAM plus linear
// stimulus with hand-derived cycle-by-cycle expectations.
module tb_insn_fetch_queue;
  import insn_fetch_queue_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush, insn_ready;
  logic [AW-1:0] start_addr;
  logic          imem_ren;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          insn_valid;
  logic [DW-1:0] insn_data;
  logic [AW-1:0] insn_addr;
  logic          busy, halted;

  logic [DW-1:0] imem [8192];
  int            n_reads = 0;
  int            n_reads_100 = 0;
  logic [AW-1:0] last_raddr = 13'h0;
  int            checks = 0;
  int            errors = 0;
  int            r0;
  logic [AW-1:0] wseq [4];

  insn_fetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .flush      (flush),
    .imem_ren   (imem_ren),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .insn_valid (insn_valid),
    .insn_data  (insn_data),
    .insn_addr  (insn_addr),
    .insn_ready (insn_ready),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency instruction memory plus read logging
  always @(posedge clk) begin
    if (imem_ren) begin
      imem_rdata <= imem[imem_addr];
      n_reads    <= n_reads + 1;
      last_raddr <= imem_addr;
      if (imem_addr == 13'h100) n_reads_100 <= n_reads_100 + 1;
    end
  end

  function automatic logic [31:0] word_at(input logic [12:0] a);
    return 32'h0800_0000 | {19'h0, a};
  endfunction

  function automatic logic [31:0] eoc_at(input logic [12:0] a);
    return {OP_EOC, 14'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ren"},    64'(imem_ren),   64'd0);
    chk({tag, "_raddr"},  64'(imem_addr),  64'd0);
    chk({tag, "_valid"},  64'(insn_valid), 64'd0);
    chk({tag, "_data"},   64'(insn_data),  64'd0);
    chk({tag, "_iaddr"},  64'(insn_addr),  64'd0);
    chk({tag, "_busy"},   64'(busy),       64'd0);
    chk({tag, "_halted"}, 64'(halted),     64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; insn_ready = 1'b1; start_addr = 13'h0;
    for (int i = 0; i < 8192; i++) imem[i] = word_at(13'(i));
    imem[13'h005] = eoc_at(13'h005);
    imem[13'h026] = eoc_at(13'h026);
    imem[13'h042] = eoc_at(13'h042);
    imem[13'h058] = eoc_at(13'h058);

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Basic stream 0..5, EOC at 5
    r0 = n_reads;
    start = 1'b1; start_addr = 13'h000;
    @(negedge clk); start = 1'b0;
    chk("basic_ren_c1", 64'(imem_ren), 64'd1);
    chk("basic_raddr_c1", 64'(imem_addr), 64'h0);
    chk("basic_busy_c1", 64'(busy), 64'd1);
    chk("basic_valid_c1", 64'(insn_valid), 64'd0);
    @(negedge clk);
    chk("basic_raddr_c2", 64'(imem_addr), 64'h1);
    chk("basic_valid_c2", 64'(insn_valid), 64'd0);
    for (int a = 0; a < 6; a++) begin
      @(negedge clk);
      chk("basic_valid", 64'(insn_valid), 64'd1);
      chk("basic_iaddr", 64'(insn_addr), 64'(a));
      chk("basic_data", 64'(insn_data), 64'((a == 5) ? eoc_at(13'(a)) : word_at(13'(a))));
    end
    chk("basic_busy_drain", 64'(busy), 64'd1);
    chk("basic_halt_drain", 64'(halted), 64'd0);
    @(negedge clk);
    chk("basic_halted", 64'(halted), 64'd1);
    chk("basic_busy_end", 64'(busy), 64'd0);
    chk("basic_valid_end", 64'(insn_valid), 64'd0);
    @(negedge clk);
    chk("basic_no_a6_push", 64'(insn_valid), 64'd0);
    chk("basic_nreads", 64'(n_reads - r0), 64'd7);
    chk("basic_last_raddr", 64'(last_raddr), 64'h6);

    // Backpressure: ready low for 10 cycles from 0x20, EOC at 0x26
    r0 = n_reads;
    insn_ready = 1'b0; start = 1'b1; start_addr = 13'h020;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) chk("bp_hold_data_k5", 64'(insn_data), 64'(word_at(13'h020)));
    end
    chk("bp_nreads", 64'(n_reads - r0), 64'd4);
    chk("bp_last_raddr", 64'(last_raddr), 64'h023);
    chk("bp_ren_off", 64'(imem_ren), 64'd0);
    chk("bp_valid", 64'(insn_valid), 64'd1);
    chk("bp_hold_iaddr", 64'(insn_addr), 64'h020);
    chk("bp_hold_data", 64'(insn_data), 64'(word_at(13'h020)));
    insn_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("bp_rel_valid", 64'(insn_valid), 64'd1);
      chk("bp_rel_iaddr", 64'(insn_addr), 64'(13'h020 + 13'(k)));
      chk("bp_rel_data", 64'(insn_data),
          64'((k == 6) ? eoc_at(13'h026) : word_at(13'h020 + 13'(k))));
    end
    @(negedge clk);
    chk("bp_halted", 64'(halted), 64'd1);

    // Flush in the cycle after the read of 0x32 is issued
    start = 1'b1; start_addr = 13'h030;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fl_raddr_c3", 64'(imem_addr), 64'h032);
    chk("fl_iaddr_c3", 64'(insn_addr), 64'h030);
    @(negedge clk);
    chk("fl_iaddr_c4", 64'(insn_addr), 64'h031);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("fl_valid_c5", 64'(insn_valid), 64'd0);
    chk("fl_busy_c5", 64'(busy), 64'd0);
    chk("fl_ren_c5", 64'(imem_ren), 64'd0);
    chk("fl_halted_c5", 64'(halted), 64'd0);
    @(negedge clk);
    chk("fl_valid_c6", 64'(insn_valid), 64'd0);
    start = 1'b1; start_addr = 13'h040;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("fl_valid_c8", 64'(insn_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_re_valid", 64'(insn_valid), 64'd1);
      chk("fl_re_iaddr", 64'(insn_addr), 64'(13'h040 + 13'(k)));
    end
    @(negedge clk);
    chk("fl_re_halted", 64'(halted), 64'd1);

    // Address wrap from 0x1FFE, EOC at 0x0001
    imem[13'h001] = eoc_at(13'h001);
    wseq[0] = 13'h1FFE; wseq[1] = 13'h1FFF; wseq[2] = 13'h0000; wseq[3] = 13'h0001;
    start = 1'b1; start_addr = 13'h1FFE;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wrap_valid", 64'(insn_valid), 64'd1);
      chk("wrap_iaddr", 64'(insn_addr), 64'(wseq[k]));
    end
    chk("wrap_eoc_data", 64'(insn_data), 64'(eoc_at(13'h001)));
    @(negedge clk);
    chk("wrap_halted", 64'(halted), 64'd1);

    // Start ignored while busy
    r0 = n_reads_100;
    start = 1'b1; start_addr = 13'h050;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("ign_valid", 64'(insn_valid), 64'd1);
      chk("ign_iaddr", 64'(insn_addr), 64'(13'h050 + 13'(k)));
      if (k == 1) begin
        start = 1'b1; start_addr = 13'h100;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("ign_halted", 64'(halted), 64'd1);
    chk("ign_no_read_100", 64'(n_reads_100 - r0), 64'd0);

    // Reset mid-stream: 3 words queued, read of 0x63 in flight
    insn_ready = 1'b0; start = 1'b1; start_addr = 13'h060;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_valid", 64'(insn_valid), 64'd1);
    chk("rst_pre_busy", 64'(busy), 64'd1);
    chk("rst_pre_last_raddr", 64'(last_raddr), 64'h063);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_all_zero("rst_mid");
    @(negedge clk);
    chk("rst_no_push_valid", 64'(insn_valid), 64'd0);
    chk("rst_no_push_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
